// File: rtl/strip_pkg.sv
// Constants shared by the strip convolution units and the result collector,
// plus the collector's FSM state encoding.
package strip_pkg;

    localparam int NUM_STRIPS = 8;
    localparam int STRIP_COLS = 222;
    localparam int STRIP_ROWS = 28;
    localparam int DATA_W     = 9;
    localparam int ADDR_W     = 16;
    localparam int RD_LATENCY = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_STRIP,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/strip_result_collector_if.sv
// Row-major output stream of the reassembled feature map (valid/ready).
interface strip_result_collector_if #(
    parameter int DATA_W = strip_pkg::DATA_W
) ();

    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic                     m_eol;
    logic                     m_eof;

    modport master (output m_valid, m_data, m_eol, m_eof, input m_ready);
    modport slave  (input m_valid, m_data, m_eol, m_eof, output m_ready);

endinterface

// File: rtl/strip_skid_fifo.sv
// First-word-fall-through FIFO with occupancy output; dout reads as zero when empty.
module strip_skid_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && (cnt_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= next_ptr(wr_q);
            if (do_pop)  rd_q <= next_ptr(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone
    // decide which entries are valid, and empty output is forced to zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign valid_o = (cnt_q != '0);
    assign dout_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/strip_result_collector.sv
// Reads each strip's result BRAM in turn once its unit reports done and streams
// the full output feature map row-major with row/frame end markers.
module strip_result_collector #(
    parameter int NUM_STRIPS = strip_pkg::NUM_STRIPS,
    parameter int STRIP_COLS = strip_pkg::STRIP_COLS,
    parameter int STRIP_ROWS = strip_pkg::STRIP_ROWS,
    parameter int DATA_W     = strip_pkg::DATA_W,
    parameter int ADDR_W     = strip_pkg::ADDR_W,
    parameter int RD_LATENCY = strip_pkg::RD_LATENCY
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_STRIPS-1:0]        strip_done,
    output logic [ADDR_W-1:0]            strip_addr,
    input  logic [NUM_STRIPS*DATA_W-1:0] strip_data,
    strip_result_collector_if.master     m,
    output logic                         busy,
    output logic                         frame_done
);

    import strip_pkg::*;

    localparam int TOTAL = STRIP_COLS * STRIP_ROWS;
    localparam int DEPTH = RD_LATENCY + 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SW    = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
    localparam int CW    = (STRIP_COLS > 1) ? $clog2(STRIP_COLS) : 1;
    localparam int FW    = DATA_W + 2;

    state_e                state_q, state_d;
    logic [SW-1:0]         strip_q, strip_d;
    logic [ADDR_W-1:0]     addr_q, addr_d, cnt_q, cnt_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [RD_LATENCY-1:0] pipe_eol_q, pipe_eol_d;
    logic [RD_LATENCY-1:0] pipe_eof_q, pipe_eof_d;

    logic              issue, pop, credit_ok, last_addr, last_strip, drained;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_valid;
    logic [FW-1:0]     fifo_dout;
    logic [DATA_W-1:0] rd_word;

    // Words in flight through the BRAM plus words queued may never exceed the
    // FIFO depth, so a stalled consumer can never cause a dropped word.
    assign credit_ok  = ($countones(pipe_vld_q) + int'(fifo_cnt)) < DEPTH;
    assign issue      = (state_q == ST_READ) && credit_ok;
    assign pop        = fifo_valid && m.m_ready;
    assign last_addr  = (cnt_q == ADDR_W'(TOTAL - 1));
    assign last_strip = (strip_q == SW'(NUM_STRIPS - 1));
    assign drained    = (pipe_vld_q == '0) &&
                        ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop));
    assign rd_word    = strip_data[int'(strip_q)*DATA_W +: DATA_W];

    // NOTE: every signal written here gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d       = state_q;
        strip_d       = strip_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        col_d         = col_q;
        pipe_vld_d    = pipe_vld_q << 1;
        pipe_eol_d    = pipe_eol_q << 1;
        pipe_eof_d    = pipe_eof_q << 1;
        pipe_vld_d[0] = issue;
        pipe_eol_d[0] = issue && (col_q == CW'(STRIP_COLS - 1));
        pipe_eof_d[0] = issue && last_addr && last_strip;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_STRIP;
                    strip_d = '0;
                    cnt_d   = '0;
                    col_d   = '0;
                end
            end
            ST_WAIT_STRIP: begin
                if (strip_done[strip_q]) state_d = ST_READ;
            end
            ST_READ: begin
                if (issue) begin
                    addr_d = cnt_q;
                    cnt_d  = cnt_q + 1'b1;
                    col_d  = (col_q == CW'(STRIP_COLS - 1)) ? '0 : col_q + 1'b1;
                    if (last_addr) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    if (last_strip) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_STRIP;
                        strip_d = strip_q + 1'b1;
                        cnt_d   = '0;
                        col_d   = '0;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            strip_q    <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            col_q      <= '0;
            pipe_vld_q <= '0;
            pipe_eol_q <= '0;
            pipe_eof_q <= '0;
        end else begin
            state_q    <= state_d;
            strip_q    <= strip_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_eol_q <= pipe_eol_d;
            pipe_eof_q <= pipe_eof_d;
        end
    end

    strip_skid_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pipe_vld_q[RD_LATENCY-1]),
        .din_i   ({pipe_eol_q[RD_LATENCY-1], pipe_eof_q[RD_LATENCY-1], rd_word}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign strip_addr = addr_q;
    assign m.m_valid  = fifo_valid;
    assign m.m_data   = fifo_dout[DATA_W-1:0];
    assign m.m_eol    = fifo_dout[FW-1];
    assign m.m_eof    = fifo_dout[FW-2];
    assign busy       = (state_q == ST_WAIT_STRIP) || (state_q == ST_READ) ||
                        (state_q == ST_DRAIN);
    assign frame_done = (state_q == ST_DONE);

endmodule
